// File: rtl/match_accelerator.sv
// match_accelerator: scans a 64x24 note bitmap one row per cycle and reports
// the pitch (from the vertical centre of the note head) and the duration (filled or hollow).
`default_nettype none

module match_accelerator (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1535:0] bmr,
  output logic [15:0]   noteReg,
  output logic [15:0]   lengthReg,
  output logic          finish
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [1535:0]   bmp_q;
  logic [5:0]      row_q;
  logic [5:0]      top_q;
  logic [5:0]      bot_q;
  logic            head_seen_q;
  logic            hollow_seen_q;
  logic [2:0]      note_q;
  logic [3:0]      len_q;
  logic            finish_q;

  logic [23:0]     row_cur;
  logic [4:0]      row_pop;
  logic [23:0]     ink_above;
  logic [23:0]     ink_below;
  logic            row_hollow;
  logic            row_is_head;
  logic [6:0]      sum7;
  logic [6:0]      c7;
  logic [6:0]      idx7;
  logic [2:0]      note_d;
  logic [3:0]      len_d;

  // The capture register is shifted up one row per SCAN cycle, so the current row is always at the top.
  assign row_cur = bmp_q[1535 -: 24];

  always_comb begin
    row_pop       = 5'd0;
    ink_above     = 24'd0;
    ink_below     = 24'd0;
    for (int i = 0; i < 24; i++) begin
      row_pop = row_pop + {4'd0, row_cur[i]};
    end
    for (int i = 22; i >= 0; i--) begin
      ink_above[i] = ink_above[i+1] | row_cur[i+1];
    end
    for (int i = 1; i < 24; i++) begin
      ink_below[i] = ink_below[i-1] | row_cur[i-1];
    end
    // A blank pixel with ink somewhere on both sides marks the interior of a hollow head.
    row_hollow  = |(~row_cur & ink_above & ink_below);
    row_is_head = (row_pop != 5'd0) && (row_pop != 5'd24);
  end

  always_comb begin
    sum7 = {1'b0, top_q} + {1'b0, bot_q};
    c7   = sum7 >> 1;
    idx7 = (c7 + 7'd4) >> 3;
    case (idx7)
      7'd0, 7'd1: note_d = 3'd7;
      7'd2:       note_d = 3'd6;
      7'd3:       note_d = 3'd5;
      7'd4:       note_d = 3'd4;
      7'd5:       note_d = 3'd3;
      7'd6:       note_d = 3'd2;
      default:    note_d = 3'd1;
    endcase
    len_d = hollow_seen_q ? 4'd8 : 4'd4;
    if (!head_seen_q) begin
      note_d = 3'd0;
      len_d  = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bmp_q         <= '0;
      row_q         <= 6'd0;
      top_q         <= 6'd0;
      bot_q         <= 6'd0;
      head_seen_q   <= 1'b0;
      hollow_seen_q <= 1'b0;
      note_q        <= 3'd0;
      len_q         <= 4'd0;
      finish_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          finish_q <= 1'b0;
          if (start) begin
            bmp_q         <= bmr;
            row_q         <= 6'd0;
            top_q         <= 6'd0;
            bot_q         <= 6'd0;
            head_seen_q   <= 1'b0;
            hollow_seen_q <= 1'b0;
            state_q       <= SCAN;
          end
        end
        SCAN: begin
          bmp_q <= bmp_q << 24;
          if (row_is_head) begin
            if (!head_seen_q) begin
              top_q <= row_q;
            end
            bot_q       <= row_q;
            head_seen_q <= 1'b1;
            if (row_hollow) begin
              hollow_seen_q <= 1'b1;
            end
          end
          row_q <= row_q + 6'd1;
          if (row_q == 6'd63) begin
            state_q <= CALC;
          end
        end
        CALC: begin
          note_q   <= note_d;
          len_q    <= len_d;
          finish_q <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          finish_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign noteReg   = {13'd0, note_q};
  assign lengthReg = {12'd0, len_q};
  assign finish    = finish_q;

endmodule

`default_nettype wire

// File: tb/tb_match_accelerator.sv
// tb_match_accelerator: directed and randomized checks of match_accelerator
// against a row-by-row behavioural model of the note recognition rules.
`default_nettype none

module tb_match_accelerator;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1535:0] bmr;
  logic [15:0]   noteReg;
  logic [15:0]   lengthReg;
  logic          finish;

  int passed = 0;
  int total  = 0;

  match_accelerator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bmr       (bmr),
    .noteReg   (noteReg),
    .lengthReg (lengthReg),
    .finish    (finish)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference: classify every row, then derive pitch and duration from the head extent.
  function automatic void model(input logic [1535:0] b, output logic [15:0] n, output logic [15:0] l);
    int tbl[9] = '{7, 7, 6, 5, 4, 3, 2, 1, 1};
    int top, bot, ones, runs, idx;
    bit hol, prev;
    logic [23:0] row;
    top = -1;
    bot = -1;
    hol = 0;
    for (int r = 0; r < 64; r++) begin
      row  = b[1535 - 24*r -: 24];
      ones = 0;
      runs = 0;
      prev = 0;
      for (int i = 23; i >= 0; i--) begin
        if (row[i]) ones++;
        if (row[i] && !prev) runs++;
        prev = row[i];
      end
      if (ones > 0 && ones < 24) begin
        if (top < 0) top = r;
        bot = r;
        if (runs >= 2) hol = 1;
      end
    end
    if (top < 0) begin
      n = 16'd0;
      l = 16'd0;
    end else begin
      idx = ((top + bot) / 2 + 4) / 8;
      n   = 16'(tbl[idx]);
      l   = hol ? 16'd8 : 16'd4;
    end
  endfunction

  function automatic logic [1535:0] head_bmp(input int t, input int bt, input bit hollow, input bit staff);
    logic [1535:0] b;
    int st[5] = '{0, 16, 32, 48, 63};
    b = '0;
    for (int r = t; r <= bt; r++) begin
      b[1535 - 24*r -: 24] = hollow ? 24'h00C300 : 24'h00FF00;
    end
    if (staff) begin
      for (int k = 0; k < 5; k++) begin
        b[1535 - 24*st[k] -: 24] = '1;
      end
    end
    return b;
  endfunction

  function automatic logic [1535:0] rand_bmp();
    logic [1535:0] b;
    int sel;
    b = '0;
    for (int r = 0; r < 64; r++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 6) b[1535 - 24*r -: 24] = '1;
      else if (sel > 6) b[1535 - 24*r -: 24] = 24'($urandom);
    end
    return b;
  endfunction

  function automatic logic [1535:0] rand_head();
    int t, bt;
    t  = int'($urandom_range(0, 63));
    bt = t + int'($urandom_range(0, 63 - t));
    return head_bmp(t, bt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endfunction

  // One recognition: launch, corrupt bmr mid-scan, check hold, latency, result and pulse width.
  task automatic run_one(input logic [1535:0] b, input string tag);
    logic [15:0] en, el, pn, pl;
    int n;
    model(b, en, el);
    @(negedge clk);
    bmr   = b;
    start = 1'b1;
    pn    = noteReg;
    pl    = lengthReg;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n     = 1;
    while (finish !== 1'b1 && n < 200) begin
      if (n == 10) bmr = ~b;
      if (n == 30) begin
        check({tag, "_hold_note"}, 32'(noteReg), 32'(pn));
        check({tag, "_hold_len"}, 32'(lengthReg), 32'(pl));
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd66);
    check({tag, "_note"}, 32'(noteReg), 32'(en));
    check({tag, "_len"}, 32'(lengthReg), 32'(el));
    @(negedge clk);
    check({tag, "_finish_width"}, 32'(finish), 32'd0);
  endtask

  initial begin
    logic [1535:0] b1;
    logic [15:0] en, el;
    int pulses;

    rst_n = 1'b0;
    start = 1'b0;
    bmr   = '0;
    #1;
    check("reset_note", 32'(noteReg), 32'd0);
    check("reset_len", 32'(lengthReg), 32'd0);
    check("reset_finish", 32'(finish), 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    run_one(head_bmp(12, 23, 1'b0, 1'b1), "filled_F");
    check("filled_F_const_note", 32'(noteReg), 32'd6);
    check("filled_F_const_len", 32'(lengthReg), 32'd4);
    run_one(head_bmp(12, 23, 1'b1, 1'b1), "hollow_F");
    check("hollow_F_const_len", 32'(lengthReg), 32'd8);
    run_one(head_bmp(50, 61, 1'b0, 1'b1), "filled_A");
    check("filled_A_const_note", 32'(noteReg), 32'd1);
    run_one(head_bmp(2, 11, 1'b0, 1'b1), "filled_G");
    check("filled_G_const_note", 32'(noteReg), 32'd7);
    run_one(head_bmp(40, 40, 1'b0, 1'b0), "single_row");
    check("single_row_const_note", 32'(noteReg), 32'd3);
    run_one('0, "all_zero");
    run_one(head_bmp(1, 0, 1'b0, 1'b1), "staff_only");
    check("staff_only_const_note", 32'(noteReg), 32'd0);

    run_one(head_bmp(12, 23, 1'b0, 1'b1), "pre_reset");
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midscan_reset_note", 32'(noteReg), 32'd0);
    check("midscan_reset_len", 32'(lengthReg), 32'd0);
    check("midscan_reset_finish", 32'(finish), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (finish === 1'b1) pulses++;
    end
    check("midscan_reset_no_finish", 32'(pulses), 32'd0);
    run_one(head_bmp(50, 61, 1'b1, 1'b1), "post_reset");

    @(negedge clk);
    start = 1'b1;
    #2;
    start = 1'b0;
    pulses = 0;
    repeat (80) begin
      @(negedge clk);
      if (finish === 1'b1) pulses++;
    end
    check("short_start_no_finish", 32'(pulses), 32'd0);

    for (int i = 0; i < 6; i++) run_one(rand_bmp(), $sformatf("rand_scatter%0d", i));
    for (int i = 0; i < 6; i++) run_one(rand_head(), $sformatf("rand_head%0d", i));

    b1 = rand_head();
    model(b1, en, el);
    @(negedge clk);
    bmr   = b1;
    start = 1'b1;
    @(posedge clk);
    pulses = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (finish === 1'b1) begin
        pulses++;
        check($sformatf("held_pulse%0d_phase", pulses), 32'(k % 67), 32'd66);
        check($sformatf("held_pulse%0d_note", pulses), 32'(noteReg), 32'(en));
        check($sformatf("held_pulse%0d_len", pulses), 32'(lengthReg), 32'(el));
      end
      bmr = ((k % 67) >= 10 && (k % 67) <= 50) ? ~b1 : b1;
      if (k == 200) start = 1'b0;
    end
    check("held_pulse_count", 32'(pulses), 32'd3);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
